// File: rtl/sr04_ranger.sv
// HC-SR04 ranging controller: periodic trigger, echo timing on a 1 MHz clock,
// and divider-free conversion of echo width to whole centimetres.
module sr04_ranger #(
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60000,
    parameter int TIMEOUT_US = 30000,
    parameter int DIV_US     = 58,
    parameter int DW         = 10
) (
    input  logic          clk_1m,
    input  logic          rst_n,
    input  logic          en,
    output logic          s1_trig,
    input  logic          s1_echo,
    output logic [DW-1:0] dist_cm,
    output logic          dist_vld,
    output logic          echo_err,
    output logic          busy
);

    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam int UW = $clog2(DIV_US + 1);
    // Headroom beyond one period: a late echo can finish after the period mark.
    localparam int PW = $clog2(PERIOD_US + TRIG_US + 2 * TIMEOUT_US + 8);

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_US - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_US - 1);
    localparam logic [UW-1:0] US_LAST   = UW'(DIV_US - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_US - 1);
    localparam logic [DW-1:0] CM_MAX    = '1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] TRIG = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] MEAS = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] HOLD = 3'd5;

    logic [2:0]    state, state_n;
    logic          err_n;
    logic          echo_m, echo_s, echo_d;
    logic          rise, fall;
    logic [TW-1:0] t_cnt;
    logic [PW-1:0] per_cnt;
    logic [UW-1:0] us_cnt;
    logic [DW-1:0] cm_cnt;

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= s1_echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;
    assign busy = (state != IDLE);

    // Rise beats timeout while waiting; timeout beats fall once the echo width reaches the limit.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            IDLE: if (en) state_n = TRIG;
            TRIG: begin
                if (!en)                     state_n = IDLE;
                else if (t_cnt == TRIG_LAST) state_n = WAIT;
            end
            WAIT: begin
                if (!en)                   state_n = IDLE;
                else if (rise)             state_n = MEAS;
                else if (t_cnt == TO_LAST) begin
                    state_n = HOLD;
                    err_n   = 1'b1;
                end
            end
            MEAS: begin
                if (!en) state_n = IDLE;
                else if (t_cnt == TO_LAST) begin
                    state_n = HOLD;
                    err_n   = 1'b1;
                end else if (fall) state_n = DONE;
            end
            DONE: state_n = HOLD;
            HOLD: begin
                if (!en)                     state_n = IDLE;
                else if (per_cnt >= PER_LAST) state_n = TRIG;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s1_trig  <= 1'b0;
            dist_cm  <= '0;
            dist_vld <= 1'b0;
            echo_err <= 1'b0;
            t_cnt    <= '0;
            per_cnt  <= '0;
            us_cnt   <= '0;
            cm_cnt   <= '0;
        end else begin
            state    <= state_n;
            s1_trig  <= (state_n == TRIG);
            echo_err <= err_n;
            dist_vld <= (state == DONE);
            if (state == DONE) dist_cm <= cm_cnt;

            if (state_n != state)                                  t_cnt <= '0;
            else if (state == TRIG || state == WAIT || state == MEAS) t_cnt <= t_cnt + TW'(1);

            if (state_n == TRIG && state != TRIG) per_cnt <= '0;
            else if (state != IDLE)               per_cnt <= per_cnt + PW'(1);

            // Every MEAS cycle counts, including the one where the fall is seen.
            if (state == WAIT) begin
                us_cnt <= '0;
                cm_cnt <= '0;
            end else if (state == MEAS) begin
                if (us_cnt == US_LAST) begin
                    us_cnt <= '0;
                    if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + DW'(1);
                end else begin
                    us_cnt <= us_cnt + UW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sr04_ranger.sv
// Directed bench for sr04_ranger, run with shortened period/timeout and a narrow dist_cm.
`timescale 1ns/1ps
module tb_sr04_ranger;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 2100;
    localparam int TIMEOUT_US = 1000;
    localparam int DIV_US     = 58;
    localparam int DW         = 4;

    logic          clk_1m = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          s1_echo = 1'b0;
    logic          s1_trig, dist_vld, echo_err, busy;
    logic [DW-1:0] dist_cm;

    int n_tests = 0;
    int n_fail  = 0;

    sr04_ranger #(
        .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US), .TIMEOUT_US(TIMEOUT_US),
        .DIV_US(DIV_US), .DW(DW)
    ) dut (
        .clk_1m(clk_1m), .rst_n(rst_n), .en(en), .s1_trig(s1_trig), .s1_echo(s1_echo),
        .dist_cm(dist_cm), .dist_vld(dist_vld), .echo_err(echo_err), .busy(busy)
    );

    always #5 clk_1m = ~clk_1m;

    // Negedges until s1_trig is seen rising.
    task automatic wait_rise(output int n, output bit ok);
        bit prev;
        prev = s1_trig;
        n = 0;
        ok = 0;
        while (n < 5000) begin
            @(negedge clk_1m);
            n++;
            if (s1_trig && !prev) begin
                ok = 1;
                break;
            end
            prev = s1_trig;
        end
    endtask

    // Called on the first high sample; returns on the first low sample (WAIT entry).
    task automatic wait_fall(output int hi, output bit ok);
        hi = 1;
        ok = 0;
        while (hi < 100) begin
            @(negedge clk_1m);
            if (!s1_trig) begin
                ok = 1;
                break;
            end
            hi++;
        end
    endtask

    task automatic pulse_echo(input int width, output int lat, output bit vld, output bit err);
        s1_echo = 1'b1;
        repeat (width) @(negedge clk_1m);
        s1_echo = 1'b0;
        lat = 0;
        vld = 0;
        err = 0;
        while (lat < 50) begin
            @(negedge clk_1m);
            lat++;
            if (dist_vld || echo_err) begin
                vld = dist_vld;
                err = echo_err;
                break;
            end
        end
    endtask

    task automatic start_wait(input string tag);
        int n;
        bit ok;
        wait_rise(n, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_trig: no trigger rise within bound", tag);
        end
        wait_fall(n, ok);
    endtask

    task automatic test_reset();
        logic [DW+3:0] got;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk_1m);
        got = {s1_trig, dist_cm, dist_vld, echo_err, busy};
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want all zero", got);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_1m);
        n_tests++;
        if (busy !== 1'b0 || s1_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_en: busy=%b trig=%b, want 0 0", busy, s1_trig);
        end
    endtask

    task automatic test_basic();
        int n, hi, lat;
        bit ok, vld, err;
        en = 1'b1;
        wait_rise(n, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_trig: no trigger rise");
        end
        wait_fall(hi, ok);
        n_tests++;
        if (hi != TRIG_US) begin
            n_fail++;
            $display("FAIL trig_width: got %0d cycles, want %0d", hi, TRIG_US);
        end
        repeat (100) @(negedge clk_1m);
        pulse_echo(580, lat, vld, err);
        n_tests++;
        if (!vld || err || lat != 4 || dist_cm !== 4'd10) begin
            n_fail++;
            $display("FAIL echo_580: vld=%b err=%b lat=%0d cm=%0d, want 1 0 4 10", vld, err, lat, dist_cm);
        end
        @(negedge clk_1m);
        n_tests++;
        if (dist_vld !== 1'b0 || dist_cm !== 4'd10) begin
            n_fail++;
            $display("FAIL vld_single: vld=%b cm=%0d, want 0 10", dist_vld, dist_cm);
        end
    endtask

    task automatic test_widths();
        int widths [3] = '{57, 58, 999};
        int exp_cm [3] = '{0, 1, 15};
        int lat;
        bit vld, err;
        for (int i = 0; i < 3; i++) begin
            start_wait("width");
            repeat (20) @(negedge clk_1m);
            pulse_echo(widths[i], lat, vld, err);
            n_tests++;
            if (!vld || err || lat != 4 || int'(dist_cm) != exp_cm[i]) begin
                n_fail++;
                $display("FAIL width_%0d: vld=%b err=%b lat=%0d cm=%0d, want 1 0 4 %0d",
                         widths[i], vld, err, lat, dist_cm, exp_cm[i]);
            end
        end
        // Echo high across WAIT entry must not count as a rise.
        begin
            int n;
            bit ok;
            wait_rise(n, ok);
            s1_echo = 1'b1;
            wait_fall(n, ok);
            repeat (50) @(negedge clk_1m);
            s1_echo = 1'b0;
            repeat (10) @(negedge clk_1m);
            pulse_echo(116, lat, vld, err);
            n_tests++;
            if (!vld || err || dist_cm !== 4'd2) begin
                n_fail++;
                $display("FAIL early_high_116: vld=%b err=%b cm=%0d, want 1 0 2", vld, err, dist_cm);
            end
        end
    endtask

    task automatic test_timeouts();
        int lat, n;
        bit vld, err, saw_vld;
        start_wait("to_width");
        repeat (20) @(negedge clk_1m);
        pulse_echo(TIMEOUT_US, lat, vld, err);
        n_tests++;
        if (vld || !err || lat != 3 || dist_cm !== 4'd2) begin
            n_fail++;
            $display("FAIL width_limit: vld=%b err=%b lat=%0d cm=%0d, want 0 1 3 2", vld, err, lat, dist_cm);
        end

        start_wait("no_echo");
        n = 0;
        saw_vld = 0;
        while (n < 2 * TIMEOUT_US) begin
            @(negedge clk_1m);
            n++;
            if (dist_vld) saw_vld = 1;
            if (echo_err) break;
        end
        n_tests++;
        if (n != TIMEOUT_US || saw_vld || dist_cm !== 4'd2) begin
            n_fail++;
            $display("FAIL no_echo: err_at=%0d vld_seen=%b cm=%0d, want %0d 0 2", n, saw_vld, dist_cm, TIMEOUT_US);
        end

        start_wait("stuck");
        repeat (20) @(negedge clk_1m);
        s1_echo = 1'b1;
        n = 0;
        saw_vld = 0;
        while (n < 2 * TIMEOUT_US) begin
            @(negedge clk_1m);
            n++;
            if (dist_vld) saw_vld = 1;
            if (echo_err) break;
        end
        repeat (1500 - n) @(negedge clk_1m);
        s1_echo = 1'b0;
        repeat (10) @(negedge clk_1m);
        n_tests++;
        if (n != TIMEOUT_US + 3 || saw_vld || dist_cm !== 4'd2) begin
            n_fail++;
            $display("FAIL stuck_high: err_at=%0d vld_seen=%b cm=%0d, want %0d 0 2", n, saw_vld, dist_cm, TIMEOUT_US + 3);
        end
    endtask

    task automatic test_period();
        int n;
        bit ok;
        wait_rise(n, ok);
        wait_rise(n, ok);
        n_tests++;
        if (!ok || n != PERIOD_US) begin
            n_fail++;
            $display("FAIL trig_period: got %0d cycles, want %0d", n, PERIOD_US);
        end
    endtask

    task automatic test_abort_reset();
        bit bad;
        start_wait("abort");
        repeat (20) @(negedge clk_1m);
        s1_echo = 1'b1;
        repeat (30) @(negedge clk_1m);
        en = 1'b0;
        repeat (2) @(negedge clk_1m);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b, want 0", busy);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk_1m);
            if (dist_vld || echo_err || s1_trig || busy) bad = 1;
        end
        s1_echo = 1'b0;
        n_tests++;
        if (bad || dist_cm !== 4'd2) begin
            n_fail++;
            $display("FAIL abort_quiet: activity=%b cm=%0d, want 0 2", bad, dist_cm);
        end
        repeat (5) @(negedge clk_1m);
        en = 1'b1;
        @(negedge clk_1m);
        n_tests++;
        if (s1_trig !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: trig=%b busy=%b, want 1 1", s1_trig, busy);
        end
        repeat (3) @(negedge clk_1m);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (s1_trig !== 1'b0 || busy !== 1'b0 || dist_cm !== '0) begin
            n_fail++;
            $display("FAIL async_reset: trig=%b busy=%b cm=%0d, want 0 0 0", s1_trig, busy, dist_cm);
        end
        @(negedge clk_1m);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk_1m);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_widths();
        test_timeouts();
        test_period();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
